// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM states, bus constants and
// the helper that decides what the responder drives on SDA in each state.
package sccb_pkg;

  // Default 7-bit device address of the OV7670 camera (0x42 write / 0x43 read).
  localparam logic [6:0] OV7670_DEV_ADDR = 7'h21;

  // SDA levels for acknowledge / not-acknowledge. NACK is also "released".
  localparam logic SCCB_ACK  = 1'b0;
  localparam logic SCCB_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_MACK   = 4'd8,
    ST_IGNORE    = 4'd9
  } sccb_state_e;

  // Level to put on SDA for the low/high phase that follows an SCL fall.
  // ACK states pull low, RDATA presents the current MSB, everything else releases.
  function automatic logic sda_drive_level(sccb_state_e st, logic tx_msb);
    logic lvl;
    lvl = SCCB_NACK;
    case (st)
      ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: lvl = SCCB_ACK;
      ST_RDATA:                             lvl = tx_msb;
      default:                              lvl = SCCB_NACK;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronises SCL/SDA into i_sysclk and derives single-cycle bus events:
// SCL rise/fall and START/STOP conditions.
module sccb_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_sysclk,
  input  logic db_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_chain;
  logic [SYNC_STAGES-1:0] sda_chain;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;

  // Synchroniser chains; idle bus level is high so reset to 1 to avoid a fake START.
  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      scl_chain <= '1;
      sda_chain <= '1;
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        scl_chain[i] <= scl_chain[i-1];
        sda_chain[i] <= sda_chain[i-1];
      end
      scl_chain[0] <= i_scl;
      sda_chain[0] <= i_sda;
      scl_prev     <= scl_chain[SYNC_STAGES-1];
      sda_prev     <= sda_chain[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_chain[SYNC_STAGES-1];
  assign sda_s     = sda_chain[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  // SDA edges only count as START/STOP when SCL was high on both samples.
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder emulating the OV7670 register interface: 256x8 register
// file, sequential writes with auto-increment, reads with master ACK/NACK,
// every accepted write exposed on o_wr_*, plus a registered debug read port.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = OV7670_DEV_ADDR,
  parameter int         HOLD_CYC    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_sysclk,
  input  logic       db_rstn,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  localparam int              HOLD_W    = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  sccb_state_e       state_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [7:0]        ptr_reg;
  logic              rw_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_pend_reg;
  logic              sda_pend_reg;
  logic [7:0]        regs [256];
  logic [7:0]        ptr_inc;
  logic [7:0]        rx_byte;

  sccb_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_sysclk (i_sysclk),
    .db_rstn  (db_rstn),
    .i_scl    (i_scl),
    .i_sda    (i_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign ptr_inc = ptr_reg + 8'd1;
  assign rx_byte = {shift_reg[6:0], sda_s};

  // Protocol FSM plus the SDA hold timer that delays every SDA change past the SCL fall.
  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      hold_cnt_reg  <= '0;
      hold_pend_reg <= 1'b0;
      sda_pend_reg  <= 1'b1;
      o_sda         <= 1'b1;
      o_busy        <= 1'b0;
      o_wr_valid    <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
    end else begin
      o_wr_valid <= 1'b0;

      if (hold_pend_reg) begin
        if (hold_cnt_reg == '0) begin
          o_sda         <= sda_pend_reg;
          hold_pend_reg <= 1'b0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg - 1'b1;
        end
      end

      // The level for the coming bit is chosen from the state reached at the last rise.
      if (scl_fall) begin
        hold_pend_reg <= 1'b1;
        hold_cnt_reg  <= HOLD_LOAD;
        sda_pend_reg  <= sda_drive_level(state_reg, shift_reg[7]);
      end

      if (stop_det) begin
        state_reg     <= ST_IDLE;
        o_sda         <= 1'b1;
        hold_pend_reg <= 1'b0;
        o_busy        <= 1'b0;
      end else if (start_det) begin
        state_reg   <= ST_DEV;
        bit_cnt_reg <= '0;
      end else if (scl_rise) begin
        case (state_reg)
          ST_DEV: begin
            shift_reg   <= rx_byte;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (shift_reg[6:0] == DEV_ADDR) begin
                state_reg <= ST_DEV_ACK;
                rw_reg    <= sda_s;
                o_busy    <= 1'b1;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
          end
          ST_DEV_ACK: begin
            bit_cnt_reg <= '0;
            if (rw_reg) begin
              state_reg <= ST_RDATA;
              shift_reg <= regs[ptr_reg];
            end else begin
              state_reg <= ST_SUB;
            end
          end
          ST_SUB: begin
            shift_reg   <= rx_byte;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ptr_reg   <= rx_byte;
              state_reg <= ST_SUB_ACK;
            end
          end
          ST_SUB_ACK: begin
            bit_cnt_reg <= '0;
            state_reg   <= ST_WDATA;
          end
          ST_WDATA: begin
            shift_reg   <= rx_byte;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              o_wr_valid <= 1'b1;
              o_wr_addr  <= ptr_reg;
              o_wr_data  <= rx_byte;
              state_reg  <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            ptr_reg     <= ptr_inc;
            bit_cnt_reg <= '0;
            state_reg   <= ST_WDATA;
          end
          ST_RDATA: begin
            shift_reg   <= {shift_reg[6:0], 1'b1};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_RD_MACK;
            end
          end
          ST_RD_MACK: begin
            bit_cnt_reg <= '0;
            if (sda_s == SCCB_ACK) begin
              ptr_reg   <= ptr_inc;
              shift_reg <= regs[ptr_inc];
              state_reg <= ST_RDATA;
            end else begin
              state_reg <= ST_IGNORE;
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  // Register file: written from the registered write strobe; debug read is registered,
  // so a same-cycle write and debug read of one address returns the old value.
  always_ff @(posedge i_sysclk or negedge db_rstn) begin
    if (!db_rstn) begin
      for (int i = 0; i < 256; i++) begin
        regs[i] <= '0;
      end
      o_dbg_data <= '0;
    end else begin
      if (o_wr_valid) begin
        regs[o_wr_addr] <= o_wr_data;
      end
      o_dbg_data <= regs[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: an open-drain SCCB master drives
// transactions and each scenario task checks its own expected values.
`timescale 1ns/1ps
module tb_sccb_responder;

  localparam int Q = 40;  // quarter SCL period in i_sysclk cycles

  logic       clk;
  logic       db_rstn;
  logic       m_scl;
  logic       m_sda;
  logic       sda_line;
  logic       o_sda;
  logic       o_busy;
  logic       o_wr_valid;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic [7:0] i_dbg_addr;
  logic [7:0] o_dbg_data;

  int n_checks = 0;
  int n_pass   = 0;

  int         wr_cnt      = 0;
  int         sda_low_cnt = 0;
  logic [7:0] wr_a_log [32];
  logic [7:0] wr_d_log [32];

  assign sda_line = m_sda & o_sda;

  sccb_responder dut (
    .i_sysclk  (clk),
    .db_rstn   (db_rstn),
    .i_scl     (m_scl),
    .i_sda     (sda_line),
    .o_sda     (o_sda),
    .o_busy    (o_busy),
    .o_wr_valid(o_wr_valid),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(o_dbg_data)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Log every write strobe cycle and count cycles where the responder pulls SDA low.
  always @(posedge clk) begin
    if (o_wr_valid === 1'b1) begin
      if (wr_cnt < 32) begin
        wr_a_log[wr_cnt] <= o_wr_addr;
        wr_d_log[wr_cnt] <= o_wr_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (o_sda === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b1; cyc(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b;    cyc(Q);
    m_scl = 1'b1; cyc(Q);
    s = sda_line; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic test_reset();
    db_rstn = 1'b0; m_scl = 1'b1; m_sda = 1'b1; i_dbg_addr = 8'h00;
    cyc(5);
    db_rstn = 1'b1;
    cyc(5);
    n_checks++; if (o_sda !== 1'b1) $display("FAIL reset_sda got=%b exp=1", o_sda); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (o_wr_valid !== 1'b0) $display("FAIL reset_wr_valid got=%b exp=0", o_wr_valid); else n_pass++;
    n_checks++; if (o_wr_addr !== 8'h00) $display("FAIL reset_wr_addr got=%h exp=00", o_wr_addr); else n_pass++;
    n_checks++; if (o_wr_data !== 8'h00) $display("FAIL reset_wr_data got=%h exp=00", o_wr_data); else n_pass++;
    n_checks++; if (o_dbg_data !== 8'h00) $display("FAIL reset_dbg got=%h exp=00", o_dbg_data); else n_pass++;
    $display("reset: sda=%b busy=%b dbg=%h", o_sda, o_busy, o_dbg_data);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h12, a1);
    write_byte(8'h80, a2);
    n_checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL write_acks got=%b exp=000", {a0, a1, a2}); else n_pass++;
    n_checks++; if (o_busy !== 1'b1) $display("FAIL write_busy_high got=%b exp=1", o_busy); else n_pass++;
    bus_stop();
    cyc(4);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL write_busy_low got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL write_pulses got=%0d exp=1", wr_cnt - w0); else n_pass++;
    n_checks++; if (wr_a_log[w0] !== 8'h12) $display("FAIL write_addr got=%h exp=12", wr_a_log[w0]); else n_pass++;
    n_checks++; if (wr_d_log[w0] !== 8'h80) $display("FAIL write_data got=%h exp=80", wr_d_log[w0]); else n_pass++;
    i_dbg_addr = 8'h12; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h80) $display("FAIL write_dbg got=%h exp=80", o_dbg_data); else n_pass++;
    $display("write: 42 12 80 acks=%b%b%b wr=%h/%h", a0, a1, a2, wr_a_log[w0], wr_d_log[w0]);
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    int w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h12, a1);
    bus_stop();
    bus_start();
    write_byte(8'h43, a2);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL read_busy_high got=%b exp=1", o_busy); else n_pass++;
    read_byte(1'b1, d);
    bus_stop();
    cyc(4);
    n_checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL read_acks got=%b exp=000", {a0, a1, a2}); else n_pass++;
    n_checks++; if (d !== 8'h80) $display("FAIL read_data got=%h exp=80", d); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL read_busy_low got=%b exp=0", o_busy); else n_pass++;
    n_checks++; if (wr_cnt !== w0) $display("FAIL read_no_write got=%0d exp=%0d", wr_cnt, w0); else n_pass++;
    $display("read: 42 12 P 43 -> %h", d);
  endtask

  task automatic test_ignore();
    logic a0, a1;
    int w0, l0;
    w0 = wr_cnt; l0 = sda_low_cnt;
    bus_start();
    write_byte(8'h60, a0);
    write_byte(8'h55, a1);
    n_checks++; if ({a0, a1} !== 2'b11) $display("FAIL ignore_nack got=%b exp=11", {a0, a1}); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL ignore_busy got=%b exp=0", o_busy); else n_pass++;
    bus_stop();
    cyc(4);
    n_checks++; if (sda_low_cnt !== l0) $display("FAIL ignore_sda_low got=%0d exp=%0d", sda_low_cnt - l0, 0); else n_pass++;
    n_checks++; if (wr_cnt !== w0) $display("FAIL ignore_no_write got=%0d exp=%0d", wr_cnt, w0); else n_pass++;
    $display("ignore: 60 55 acks=%b%b", a0, a1);
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'hFF, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    bus_stop();
    cyc(4);
    n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL wrap_acks got=%b exp=0000", {a0, a1, a2, a3}); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 2) $display("FAIL wrap_pulses got=%0d exp=2", wr_cnt - w0); else n_pass++;
    n_checks++; if ({wr_a_log[w0], wr_d_log[w0]} !== 16'hFF11) $display("FAIL wrap_first got=%h%h exp=FF11", wr_a_log[w0], wr_d_log[w0]); else n_pass++;
    n_checks++; if ({wr_a_log[w0+1], wr_d_log[w0+1]} !== 16'h0022) $display("FAIL wrap_second got=%h%h exp=0022", wr_a_log[w0+1], wr_d_log[w0+1]); else n_pass++;
    i_dbg_addr = 8'hFF; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h11) $display("FAIL wrap_dbg_ff got=%h exp=11", o_dbg_data); else n_pass++;
    i_dbg_addr = 8'h00; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h22) $display("FAIL wrap_dbg_00 got=%h exp=22", o_dbg_data); else n_pass++;
    $display("wrap: 42 FF 11 22 -> writes %h/%h %h/%h", wr_a_log[w0], wr_d_log[w0], wr_a_log[w0+1], wr_d_log[w0+1]);
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2, a3, b0, b1, b2;
    logic [7:0] d0, d1;
    bus_start();
    write_byte(8'h42, a0);
    write_byte(8'h05, a1);
    write_byte(8'hA5, a2);
    write_byte(8'h3C, a3);
    bus_stop();
    n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL rs_preload_acks got=%b exp=0000", {a0, a1, a2, a3}); else n_pass++;
    bus_start();
    write_byte(8'h42, b0);
    write_byte(8'h05, b1);
    bus_start();
    write_byte(8'h43, b2);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    bus_stop();
    n_checks++; if ({b0, b1, b2} !== 3'b000) $display("FAIL rs_acks got=%b exp=000", {b0, b1, b2}); else n_pass++;
    n_checks++; if (d0 !== 8'hA5) $display("FAIL rs_byte0 got=%h exp=A5", d0); else n_pass++;
    n_checks++; if (d1 !== 8'h3C) $display("FAIL rs_byte1 got=%h exp=3C", d1); else n_pass++;
    $display("repeated_start: 42 05 Sr 43 -> %h %h", d0, d1);
  endtask

  task automatic test_hold_and_reset();
    logic s;
    bus_start();
    for (int i = 7; i >= 1; i--) bus_bit(8'h42 >> i, s);
    // last address bit (R/W=0) by hand to watch the ACK edge after the SCL fall
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(2 * Q);
    m_scl = 1'b0; cyc(12);
    n_checks++; if (o_sda !== 1'b1) $display("FAIL hold_not_early got=%b exp=1", o_sda); else n_pass++;
    cyc(12);
    n_checks++; if (o_sda !== 1'b0) $display("FAIL hold_ack_driven got=%b exp=0", o_sda); else n_pass++;
    cyc(Q - 24);
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q / 2);
    n_checks++; if (sda_line !== 1'b0) $display("FAIL hold_ack_high got=%b exp=0", sda_line); else n_pass++;
    @(posedge clk);
    #3 db_rstn = 1'b0;
    #1;
    n_checks++; if (o_sda !== 1'b1) $display("FAIL async_release got=%b exp=1", o_sda); else n_pass++;
    cyc(3);
    n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", o_busy); else n_pass++;
    db_rstn = 1'b1;
    cyc(5);
    i_dbg_addr = 8'h12; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h00) $display("FAIL rst_clear_12 got=%h exp=00", o_dbg_data); else n_pass++;
    i_dbg_addr = 8'hFF; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h00) $display("FAIL rst_clear_ff got=%h exp=00", o_dbg_data); else n_pass++;
    i_dbg_addr = 8'h06; cyc(2);
    n_checks++; if (o_dbg_data !== 8'h00) $display("FAIL rst_clear_06 got=%h exp=00", o_dbg_data); else n_pass++;
    $display("hold_and_reset: ack after hold, reset released sda=%b dbg06=%h", o_sda, o_dbg_data);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore();
    test_wrap();
    test_repeated_start();
    test_hold_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
